// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: per-register pending writes, operand forwarding, stall/flush control.
// Latency: control outputs are combinational; the scoreboard updates on the edge after an issue or retire.
// Backpressure: asserts stall_f/stall_d and bubbles E while a hazard holds; redirect overrides the stall with a flush.
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = $clog2(NREG),
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 4,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_use1,
  input  logic              d_use2,
  input  logic [AW-1:0]     d_rs1,
  input  logic [AW-1:0]     d_rs2,
  input  logic [AW-1:0]     d_rd,
  input  logic              d_regwrite,
  input  logic              d_is_div,
  input  logic              e_valid,
  input  logic              e_regwrite,
  input  logic              e_is_load,
  input  logic              e_is_mul,
  input  logic              e_is_div,
  input  logic [AW-1:0]     e_rd,
  input  logic [AW-1:0]     e_rs1,
  input  logic [AW-1:0]     e_rs2,
  input  logic              e_use1,
  input  logic              e_use2,
  input  logic              m_regwrite,
  input  logic              w_regwrite,
  input  logic [AW-1:0]     m_rd,
  input  logic [AW-1:0]     w_rd,
  input  logic              div_done,
  input  logic [AW-1:0]     div_rd,
  input  logic              redirect,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [NREG-1:0]   busy,
  output logic [PERF_W-1:0] stall_cnt
);

  logic [NREG-1:0]            busy_q;
  logic [NREG-1:0]            div_own_q;  // busy bit is owned by the divider, not a countdown
  logic [NREG-1:0][CNT_W-1:0] cnt_q;
  logic                       div_busy_q;
  logic [PERF_W-1:0]          stall_cnt_q;

  logic long_issue;
  logic div_issue;
  logic load_in_e;
  logic src1_ok;
  logic src2_ok;
  logic hz_raw;
  logic hz_ld;
  logic hz_waw;
  logic hz_div;
  logic hold;

  assign long_issue = e_valid & e_regwrite & (e_is_mul | e_is_div) & (e_rd != '0);
  assign div_issue  = e_valid & e_is_div;
  assign load_in_e  = e_valid & e_is_load & e_regwrite;
  assign src1_ok    = d_use1 & (d_rs1 != '0);
  assign src2_ok    = d_use2 & (d_rs2 != '0);

  // Per-register scoreboard: issue sets (and wins over any clear), mul counts down, div waits for its retire pulse.
  // Register 0 is never written here, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      div_own_q <= '0;
      cnt_q     <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (long_issue && (e_rd == AW'(i))) begin
          busy_q[i]    <= 1'b1;
          div_own_q[i] <= e_is_div;
          cnt_q[i]     <= e_is_div ? '0 : CNT_W'(MUL_LAT);
        end else if (div_own_q[i]) begin
          if (div_done && (div_rd == AW'(i))) begin
            busy_q[i]    <= 1'b0;
            div_own_q[i] <= 1'b0;
          end
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
          if (cnt_q[i] == CNT_W'(1)) begin
            busy_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Divider occupancy: a new divide issue takes priority over a same-cycle retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_busy_q <= 1'b0;
    end else if (div_issue) begin
      div_busy_q <= 1'b1;
    end else if (div_done) begin
      div_busy_q <= 1'b0;
    end
  end

  // Hazard detection against the scoreboard and the instruction currently in E.
  always_comb begin
    hz_raw = 1'b0;
    hz_ld  = 1'b0;
    hz_waw = 1'b0;
    hz_div = 1'b0;
    if (src1_ok && (busy_q[d_rs1] || (long_issue && (d_rs1 == e_rd)))) hz_raw = 1'b1;
    if (src2_ok && (busy_q[d_rs2] || (long_issue && (d_rs2 == e_rd)))) hz_raw = 1'b1;
    if (load_in_e && ((src1_ok && (d_rs1 == e_rd)) || (src2_ok && (d_rs2 == e_rd)))) hz_ld = 1'b1;
    if (d_regwrite && (d_rd != '0) && (busy_q[d_rd] || (long_issue && (d_rd == e_rd)))) hz_waw = 1'b1;
    if (d_is_div && (div_busy_q || div_issue)) hz_div = 1'b1;
  end

  assign hold    = hz_raw | hz_ld | hz_waw | hz_div;
  assign stall_f = hold & ~redirect;
  assign stall_d = hold & ~redirect;
  assign flush_d = redirect;
  assign flush_e = redirect | hold;
  assign busy    = busy_q;

  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [AW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && (rs != '0)) begin
      if (m_regwrite && (m_rd == rs))      sel = 2'b10;
      else if (w_regwrite && (w_rd == rs)) sel = 2'b01;
    end
    return sel;
  endfunction

  // Operand bypass selects for E: the younger producer in M has priority over W.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    fwd_a = fwd_sel(e_use1, e_rs1);
    fwd_b = fwd_sel(e_use2, e_rs2);
  end

  // Stall-cycle performance counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_f && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each task drives one scenario and checks inline.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after it.
// Small PERF_W so counter saturation is reachable in a few cycles.
module tb_hazard_scoreboard;

  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int MUL_LAT = 3;
  localparam int CNT_W   = 4;
  localparam int PERF_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              d_use1, d_use2;
  logic [AW-1:0]     d_rs1, d_rs2, d_rd;
  logic              d_regwrite, d_is_div;
  logic              e_valid, e_regwrite, e_is_load, e_is_mul, e_is_div;
  logic [AW-1:0]     e_rd, e_rs1, e_rs2;
  logic              e_use1, e_use2;
  logic              m_regwrite, w_regwrite;
  logic [AW-1:0]     m_rd, w_rd;
  logic              div_done;
  logic [AW-1:0]     div_rd;
  logic              redirect;
  logic              stall_f, stall_d, flush_d, flush_e;
  logic [1:0]        fwd_a, fwd_b;
  logic [NREG-1:0]   busy;
  logic [PERF_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_scoreboard #(
    .NREG(NREG), .AW(AW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .d_use1(d_use1), .d_use2(d_use2), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_regwrite(d_regwrite), .d_is_div(d_is_div),
    .e_valid(e_valid), .e_regwrite(e_regwrite), .e_is_load(e_is_load),
    .e_is_mul(e_is_mul), .e_is_div(e_is_div),
    .e_rd(e_rd), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_use1(e_use1), .e_use2(e_use2),
    .m_regwrite(m_regwrite), .w_regwrite(w_regwrite), .m_rd(m_rd), .w_rd(w_rd),
    .div_done(div_done), .div_rd(div_rd), .redirect(redirect),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_inputs();
    d_use1 = 0; d_use2 = 0; d_rs1 = '0; d_rs2 = '0; d_rd = '0;
    d_regwrite = 0; d_is_div = 0;
    e_valid = 0; e_regwrite = 0; e_is_load = 0; e_is_mul = 0; e_is_div = 0;
    e_rd = '0; e_rs1 = '0; e_rs2 = '0; e_use1 = 0; e_use2 = 0;
    m_regwrite = 0; w_regwrite = 0; m_rd = '0; w_rd = '0;
    div_done = 0; div_rd = '0; redirect = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clr_inputs();
    #3;
    n_cmp++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 0000", {stall_f, stall_d, flush_d, flush_e});
    end
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_fwd: got %b want 0000", {fwd_a, fwd_b});
    end
    n_cmp++;
    if (busy !== '0) begin
      n_bad++; $display("FAIL reset_busy: got %h want 0", busy);
    end
    n_cmp++;
    if (stall_cnt !== '0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_mul();
    do_reset();
    clr_inputs();
    e_valid = 1; e_regwrite = 1; e_is_mul = 1; e_rd = 5'd5;
    #2;
    n_cmp++;
    if (stall_f !== 1'b0) begin
      n_bad++; $display("FAIL mul_c0_stall: got %b want 0", stall_f);
    end
    tick();
    clr_inputs();
    d_use1 = 1; d_rs1 = 5'd5; d_regwrite = 1; d_rd = 5'd6;
    for (int c = 1; c <= 3; c++) begin
      #2;
      n_cmp++;
      if ({stall_f, stall_d, flush_e, busy[5]} !== 4'b1111) begin
        n_bad++; $display("FAIL mul_c%0d_stall: got %b want 1111", c, {stall_f, stall_d, flush_e, busy[5]});
      end
      tick();
    end
    #2;
    n_cmp++;
    if ({stall_f, busy[5]} !== 2'b00) begin
      n_bad++; $display("FAIL mul_c4_release: got %b want 00", {stall_f, busy[5]});
    end
    n_cmp++;
    if (stall_cnt !== 4'd3) begin
      n_bad++; $display("FAIL mul_stall_cnt: got %0d want 3", stall_cnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    clr_inputs();
    e_valid = 1; e_regwrite = 1; e_is_load = 1; e_rd = 5'd7;
    d_use1 = 1; d_rs1 = 5'd7;
    #2;
    n_cmp++;
    if ({stall_f, stall_d, flush_e, flush_d} !== 4'b1110) begin
      n_bad++; $display("FAIL load_stall: got %b want 1110", {stall_f, stall_d, flush_e, flush_d});
    end
    n_cmp++;
    if (busy[7] !== 1'b0) begin
      n_bad++; $display("FAIL load_no_busy: got %b want 0", busy[7]);
    end
    tick();
    clr_inputs();
    m_regwrite = 1; m_rd = 5'd7;
    e_valid = 1; e_use1 = 1; e_rs1 = 5'd7;
    #2;
    n_cmp++;
    if ({stall_f, flush_e, fwd_a} !== 4'b0010) begin
      n_bad++; $display("FAIL load_fwd: got %b want 0010", {stall_f, flush_e, fwd_a});
    end
    tick();
  endtask

  task automatic test_div();
    clr_inputs();
    e_valid = 1; e_regwrite = 1; e_is_div = 1; e_rd = 5'd9;
    d_is_div = 1; d_regwrite = 1; d_rd = 5'd10;
    #2;
    n_cmp++;
    if (stall_f !== 1'b1) begin
      n_bad++; $display("FAIL div_e_stall: got %b want 1", stall_f);
    end
    tick();
    clr_inputs();
    d_is_div = 1; d_regwrite = 1; d_rd = 5'd10;
    for (int c = 1; c <= 2; c++) begin
      #2;
      n_cmp++;
      if ({stall_f, busy[9]} !== 2'b11) begin
        n_bad++; $display("FAIL div_wait_c%0d: got %b want 11", c, {stall_f, busy[9]});
      end
      tick();
    end
    div_done = 1; div_rd = 5'd9;
    #2;
    n_cmp++;
    if ({stall_f, busy[9]} !== 2'b11) begin
      n_bad++; $display("FAIL div_done_cycle: got %b want 11", {stall_f, busy[9]});
    end
    tick();
    div_done = 0; div_rd = '0;
    #2;
    n_cmp++;
    if ({stall_f, busy[9]} !== 2'b00) begin
      n_bad++; $display("FAIL div_after_done: got %b want 00", {stall_f, busy[9]});
    end
    tick();
    clr_inputs();
    e_valid = 1; e_regwrite = 1; e_is_div = 1; e_rd = 5'd11;
    tick();
    e_rd = 5'd12;
    div_done = 1; div_rd = 5'd11;
    tick();
    clr_inputs();
    d_is_div = 1;
    #2;
    n_cmp++;
    if ({stall_f, busy[11], busy[12]} !== 3'b101) begin
      n_bad++; $display("FAIL div_set_wins: got %b want 101", {stall_f, busy[11], busy[12]});
    end
    div_done = 1; div_rd = 5'd12;
    tick();
    div_done = 0; div_rd = '0;
    #2;
    n_cmp++;
    if ({stall_f, busy[12]} !== 2'b00) begin
      n_bad++; $display("FAIL div_drain: got %b want 00", {stall_f, busy[12]});
    end
    tick();
  endtask

  task automatic test_redirect();
    clr_inputs();
    e_valid = 1; e_regwrite = 1; e_is_mul = 1; e_rd = 5'd3;
    tick();
    clr_inputs();
    d_use2 = 1; d_rs2 = 5'd3; redirect = 1;
    #2;
    n_cmp++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
      n_bad++; $display("FAIL redir_ctl: got %b want 0011", {stall_f, stall_d, flush_d, flush_e});
    end
    tick();
    redirect = 0;
    #2;
    n_cmp++;
    if ({busy[3], stall_f} !== 2'b11) begin
      n_bad++; $display("FAIL redir_busy_kept: got %b want 11", {busy[3], stall_f});
    end
    tick();
    tick();
    #2;
    n_cmp++;
    if ({busy[3], stall_f} !== 2'b00) begin
      n_bad++; $display("FAIL redir_mul_done: got %b want 00", {busy[3], stall_f});
    end
    tick();
  endtask

  task automatic test_forward();
    clr_inputs();
    m_regwrite = 1; m_rd = 5'd4; w_regwrite = 1; w_rd = 5'd4;
    e_use1 = 1; e_rs1 = 5'd4; e_use2 = 0; e_rs2 = 5'd4;
    #2;
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b1000) begin
      n_bad++; $display("FAIL fwd_m_prio: got %b want 1000", {fwd_a, fwd_b});
    end
    e_rs1 = 5'd0;
    #2;
    n_cmp++;
    if (fwd_a !== 2'b00) begin
      n_bad++; $display("FAIL fwd_x0: got %b want 00", fwd_a);
    end
    m_rd = 5'd8; e_rs1 = 5'd4; e_use2 = 1; e_rs2 = 5'd8;
    #2;
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b0110) begin
      n_bad++; $display("FAIL fwd_w_and_m: got %b want 0110", {fwd_a, fwd_b});
    end
    m_regwrite = 0;
    #2;
    n_cmp++;
    if ({fwd_a, fwd_b} !== 4'b0100) begin
      n_bad++; $display("FAIL fwd_m_off: got %b want 0100", {fwd_a, fwd_b});
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    clr_inputs();
    e_valid = 1; e_regwrite = 1; e_is_mul = 1; e_rd = 5'd5;
    tick();
    clr_inputs();
    n_cmp++;
    if (busy[5] !== 1'b1) begin
      n_bad++; $display("FAIL rst_mul_pre: got %b want 1", busy[5]);
    end
    #1;
    rst_n = 0;
    #1;
    n_cmp++;
    if (busy !== '0) begin
      n_bad++; $display("FAIL rst_async_busy: got %h want 0", busy);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    clr_inputs();
    e_valid = 1; e_is_div = 1; d_is_div = 1;
    for (int c = 0; c < 14; c++) tick();
    #2;
    n_cmp++;
    if ({stall_f, stall_cnt} !== {1'b1, 4'd14}) begin
      n_bad++; $display("FAIL sat_pre: got %b/%0d want 1/14", stall_f, stall_cnt);
    end
    for (int c = 0; c < 6; c++) tick();
    #2;
    n_cmp++;
    if ({stall_f, stall_cnt} !== {1'b1, 4'd15}) begin
      n_bad++; $display("FAIL sat_hold: got %b/%0d want 1/15", stall_f, stall_cnt);
    end
    clr_inputs();
    tick();
  endtask

  initial begin
    clr_inputs();
    rst_n = 0;
    test_reset();
    test_mul();
    test_load_use();
    test_div();
    test_redirect();
    test_forward();
    test_reset_mid_mul();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameters: NREG, default 32, architectural register count; AW, default $clog2(NREG), register address width; MUL_LAT, default 3, fixed pipelined-multiplier latency in cycles (1..2^CNT_W-1); CNT_W, default 4, latency counter width; PERF_W, default 32, stall counter width.
REQ-002 SHALL have ports, clock and reset first:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
d_use1, d_use2  in  1  decode instruction reads rs1 / rs2
d_rs1, d_rs2, d_rd  in  AW  decode source and destination addresses
d_regwrite, d_is_div  in  1  decode writes rd / is a divide
e_valid, e_regwrite, e_is_load, e_is_mul, e_is_div  in  1  execute-stage instruction attributes
e_rd, e_rs1, e_rs2  in  AW  execute destination and sources
e_use1, e_use2  in  1  execute reads rs1 / rs2
m_regwrite, w_regwrite  in  1  memory / writeback stage writes a register
m_rd, w_rd  in  AW  memory / writeback destinations
div_done  in  1  one-cycle pulse when the divider retires
div_rd  in  AW  destination of the retiring divide
redirect  in  1  execute-stage mispredict or jump correction
stall_f, stall_d, flush_d, flush_e  out  1  pipeline control
fwd_a, fwd_b  out  2  execute operand select: 00 register file, 01 writeback, 10 memory
busy  out  NREG  per-register pending-write scoreboard
stall_cnt  out  PERF_W  saturating stall-cycle counter

Function
REQ-003 SHALL define long_issue = e_valid & e_regwrite & (e_is_mul | e_is_div) & (e_rd != 0); on long_issue, busy[e_rd] SHALL set at the next edge.
REQ-004 For a multiply issue, the block SHALL load that register's counter with MUL_LAT and decrement it once per cycle. busy SHALL clear on the edge at which the counter reaches 0, i.e. exactly MUL_LAT cycles after the issue edge.
REQ-005 For a divide issue, busy[e_rd] SHALL stay set until the edge following a div_done for that register. div_done SHALL also clear internal div_busy.
REQ-006 Divide issue SHALL set div_busy. If the divider issues and div_done occurs in the same cycle, set SHALL win.
REQ-007 If a set and a clear hit the same register in one cycle, set SHALL win. busy[0] SHALL always be 0.
REQ-008 hz_raw SHALL assert when any of the following holds for a used, nonzero decode source:
- the source equals a set busy bit; or
- the source equals e_rd while long_issue is true.
REQ-009 hz_ld SHALL assert when e_valid & e_is_load & e_regwrite hold and a used, nonzero decode source equals e_rd.
REQ-010 hz_waw SHALL assert when d_regwrite holds, d_rd is nonzero, and d_rd is busy or equals e_rd under long_issue.
REQ-011 hz_div SHALL assert when d_is_div holds and either div_busy is set or a divide is in E.
REQ-012 hold = hz_raw | hz_ld | hz_waw | hz_div.
- stall_f = stall_d = hold & ~redirect.
- flush_d = redirect.
- flush_e = redirect | hold.
- Redirect in the same cycle as a hazard SHALL flush, not stall.
REQ-013 fwd_a SHALL be computed when e_use1 holds and e_rs1 is nonzero:
- 10 if m_regwrite & (m_rd == e_rs1);
- else 01 if w_regwrite & (w_rd == e_rs1);
- else 00.
fwd_b SHALL follow the same rules on e_rs2/e_use2. Both selects SHALL be 00 otherwise.
REQ-014 stall_cnt SHALL increment on every edge where stall_f = 1 and SHALL saturate at all-ones without wrapping.
REQ-015 redirect SHALL NOT clear busy bits, counters or div_busy, because issued long operations complete regardless.
REQ-016 Control outputs SHALL be combinational from inputs and registered state, with no added latency.

Reset
REQ-017 rst_n low SHALL asynchronously clear busy, all counters, div_busy and stall_cnt. Any in-flight long operation SHALL be forgotten.
REQ-018 With reset held and all inputs 0, every output SHALL be 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- MUL_LAT=3: mul x5 issues at cycle 0; decode add reads x5 at cycle 1 -> stall_f=1 for cycles 1-3, 0 at cycle 4, stall_cnt=3.
- Load x7 in E; decode reads x7 -> stall_f=1 and flush_e=1 for exactly one cycle; next cycle fwd_a=10 when x7 is at M.
- Divide x9 issued; second divide in D -> stalled until div_done; busy[9] clears one edge after div_done; div issue and div_done in the same cycle leaves div_busy=1.
- hz_raw active with redirect=1 -> stall_f=0, flush_d=1, flush_e=1; busy unchanged.
- m_rd = w_rd = e_rs1 = 4, both writes active -> fwd_a=10; e_rs1=0 -> fwd_a=00.
- rst_n dropped mid-mul -> busy=0 immediately with no clock edge; stall_cnt forced to all-ones holds through further stalls.
